// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter with run-time writable relative/absolute branch-target table
module pc_branch_unit #(
  parameter int             D     = 12,
  parameter int             A     = 5,
  parameter logic [D-1:0]   START = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt,
  input  logic         br_taken,
  input  logic [A-1:0] br_sel,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_abs,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done
);

  localparam int DEPTH = 2 ** A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [D-1:0]   tbl_val [DEPTH];
  logic [DEPTH-1:0] tbl_abs;

  logic           bypass;
  logic [D-1:0]   sel_val;
  logic           sel_abs;
  logic [D-1:0]   branch_pc;
  logic [D-1:0]   inc_pc;

  // A write to the entry being branched through this cycle is forwarded,
  // so control never sees a stale target.
  always_comb begin
    bypass    = wr_en && (wr_addr == br_sel);
    sel_val   = bypass ? wr_data : tbl_val[br_sel];
    sel_abs   = bypass ? wr_abs  : tbl_abs[br_sel];
    // Same-width add is modulo 2**D, which is exactly sign-extended offset arithmetic.
    branch_pc = sel_abs ? sel_val : (pc + sel_val);
    inc_pc    = pc + D'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_val[i] <= '0;
      end
      tbl_abs <= '0;
    end else if (wr_en) begin
      tbl_val[wr_addr] <= wr_data;
      tbl_abs[wr_addr] <= wr_abs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            pc      <= START;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (halt) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (br_taken) begin
            pc <= branch_pc;
          end else begin
            pc <= inc_pc;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - vector table, hand sequences and randomized model check for pc_branch_unit
module tb_pc_branch_unit;

  localparam int D = 12;
  localparam int A = 5;
  localparam int START = 0;
  localparam int MOD = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, halt, br_taken, wr_en, wr_abs;
  logic [A-1:0] br_sel, wr_addr;
  logic [D-1:0] wr_data;
  logic [D-1:0] pc;
  logic         running, done;

  int checks = 0;
  int failures = 0;

  pc_branch_unit #(.D(D), .A(A), .START(START)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .br_taken(br_taken),
    .br_sel(br_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_abs(wr_abs), .pc(pc), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start, halt, br;
    logic [A-1:0] sel;
    logic         wr;
    logic [A-1:0] wa;
    logic [D-1:0] wd;
    logic         wabs;
    int           epc;
    logic         erun, edone;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: state 0 idle, 1 run, 2 done
  int m_state, m_pc;
  int m_val [32];
  bit m_abs [32];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic b, input int sel,
                       input logic w, input int wa, input int wd, input logic wab);
    start = s; halt = h; br_taken = b; br_sel = A'(sel);
    wr_en = w; wr_addr = A'(wa); wr_data = D'(wd); wr_abs = wab;
  endtask

  function automatic vec_t mk(input logic s, input logic h, input logic b, input int sel,
                              input logic w, input int wa, input int wd, input logic wab,
                              input int epc, input logic er, input logic ed);
    vec_t v;
    v.start = s; v.halt = h; v.br = b; v.sel = A'(sel);
    v.wr = w; v.wa = A'(wa); v.wd = D'(wd); v.wabs = wab;
    v.epc = epc; v.erun = er; v.edone = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc = 0;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0;
      m_abs[i] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit h, input bit b, input int sel,
                            input bit w, input int wa, input int wd, input bit wab);
    int val, off;
    bit ab;
    val = (w && wa == sel) ? wd : m_val[sel];
    ab  = (w && wa == sel) ? wab : m_abs[sel];
    if (m_state != 1) begin
      if (s) begin
        m_state = 1;
        m_pc = START;
      end
    end else if (h) begin
      m_state = 2;
    end else if (b) begin
      if (ab) m_pc = val;
      else begin
        off = (val >= MOD / 2) ? val - MOD : val;
        m_pc = ((m_pc + off) % MOD + MOD) % MOD;
      end
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
    if (w) begin
      m_val[wa] = wd;
      m_abs[wa] = wab;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_pc", int'(pc), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_done", int'(done), 0);
    step();
    reset = 1'b0;

    // start then plain increments
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0));
    // table loads during run; writes do not disturb increment
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4092, 0, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 100, 1, 7, 1, 0));
    for (int i = 8; i <= 10; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 6, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 100, 1, 0));
    // same-cycle write and branch to entry 7 uses the new value
    vecs.push_back(mk(0, 0, 1, 7, 1, 7, 42, 1, 42, 1, 0));
    // wrap: reach 4095, increment to 0, then 1 - 3 -> 4094
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 4095, 1, 43, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, 4095, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6, 4093, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 6, 0, 0, 0, 0, 4094, 1, 0));
    // relative 0 holds pc
    vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, 4094, 1, 0));
    // halt beats branch; branch/increment ignored in DONE; start re-enters RUN
    vecs.push_back(mk(0, 1, 1, 4, 0, 0, 0, 0, 4094, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 4094, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4094, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, START, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, START + 1, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].br, int'(vecs[i].sel),
            vecs[i].wr, int'(vecs[i].wa), int'(vecs[i].wd), vecs[i].wabs);
      step();
      chk($sformatf("vec%0d_pc", i), int'(pc), vecs[i].epc);
      chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].erun));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].edone));
    end

    // reset between edges with a pending write to entry 3
    drive(0, 0, 0, 0, 1, 3, 4090, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_reset_pc", int'(pc), 0);
    chk("midrun_reset_running", int'(running), 0);
    step();
    reset = 1'b0;
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    step();
    chk("idle_branch_pc", int'(pc), 0);
    chk("idle_branch_running", int'(running), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("restart_pc", int'(pc), START);
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    step();
    chk("cleared_entry_pc", int'(pc), START);
    chk("cleared_entry_running", int'(running), 1);

    // randomized run against the reference model
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit s, h, b, w, wab;
      int sel, wa, wd;
      s   = ($urandom_range(99) < 8);
      h   = ($urandom_range(99) < 4);
      b   = ($urandom_range(99) < 35);
      w   = ($urandom_range(99) < 40);
      sel = $urandom_range(7);
      wa  = $urandom_range(7);
      wab = ($urandom_range(3) == 0);
      wd  = ($urandom_range(1) == 0) ? $urandom_range(MOD - 1)
                                     : (($urandom_range(15) + MOD - 8) % MOD);
      drive(s, h, b, sel, w, wa, wd, wab);
      model_edge(s, h, b, sel, w, wa, wd, wab);
      step();
      chk($sformatf("rand%0d_pc", n), int'(pc), m_pc);
      chk($sformatf("rand%0d_running", n), int'(running), int'(m_state == 1));
      chk($sformatf("rand%0d_done", n), int'(done), int'(m_state == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
